data_mem_arb: RTL
=================

# data_mem_arb

Two-master arbiter for the data memory port. Master 0 is the core's memory stage, with single-cycle combinational access. Master 1 is a burst master such as a debug or DMA engine, using a word-incrementing burst. The block sits between `mem_ctrl`/external master and `data_mem`, and drives the pipeline hold line (`hold_flag_i` of `pc_reg`/`id_ex`) when the core must wait.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `LEN_W`, 4, burst length field width; a burst is `len+1` beats, max 2^LEN_W

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `m0_req_i`  in  1  core access request (combinational from memory stage)
- `m0_we_i`  in  1  core write enable
- `m0_raddr_i`, `m0_waddr_i`  in  ADDR_W  core read/write address
- `m0_wdata_i`  in  DATA_W  core write data
- `m0_rdata_o`  out  DATA_W  core read data, equal to `mem_rdata_i`
- `hold_o`  out  1  pipeline hold; core request not served this cycle
- `m1_req_i`  in  1  burst request
- `m1_we_i`  in  1  burst direction, 1 = write
- `m1_addr_i`  in  ADDR_W  burst base; bits [1:0] ignored
- `m1_len_i`  in  LEN_W  beats minus one
- `m1_ack_o`  out  1  burst accepted; command sampled this cycle
- `m1_beat_o`  out  1  beat performed this cycle; write data consumed
- `m1_wdata_i`  in  DATA_W  write data, must be valid while `m1_beat_o`=1
- `m1_rdata_o`  out  DATA_W  registered read data
- `m1_rvalid_o`  out  1  `m1_rdata_o` valid, one cycle after the read beat
- `m1_done_o`  out  1  high during the last beat
- `mem_req_o`, `mem_we_o`  out  1  to `data_mem`
- `mem_raddr_o`, `mem_waddr_o`  out  ADDR_W  to `data_mem`
- `mem_wdata_o`  out  DATA_W  to `data_mem`
- `mem_rdata_i`  in  DATA_W  from `data_mem`, combinational read

## Operation
FSM states are IDLE and BURST.

IDLE:
- Memory is owned by m0. The `mem_*` outputs follow the m0 inputs. `mem_req_o` = `m0_req_i`; `mem_we_o` = `m0_req_i & m0_we_i`.
- `hold_o` = 0.
- `m1_ack_o` = `m1_req_i`. On ack:
  - latch base `{m1_addr_i[ADDR_W-1:2],2'b00}`, `we` and `len`;
  - clear beat counter `cnt`;
  - next state is BURST.
- The accept cycle performs no m1 memory access, so m0 is still served in it.

BURST:
- Memory is owned by m1, with `mem_req_o` = 1.
- Beat address = base + 4*cnt, modulo 2^ADDR_W (wraps through zero). It drives both `mem_raddr_o` and `mem_waddr_o`.
- Write burst: `mem_we_o` = 1, `mem_wdata_o` = `m1_wdata_i`.
- Read burst: `mem_we_o` = 0. On each beat, register `mem_rdata_i` into `m1_rdata_o`, and set `m1_rvalid_o` = 1 in the next cycle; otherwise `m1_rvalid_o` = 0.
- `m1_beat_o` = 1 every BURST cycle.
- `cnt` increments each beat. When `cnt`==len, `m1_done_o` = 1 and the next state is IDLE.
- `hold_o` = `m0_req_i`. m0 writes are blocked (`mem_we_o` is driven only by the burst).
- `m1_req_i` and `m1_ack_o` are ignored / held 0 in BURST.

Fairness:
- Back-to-back bursts always pass through at least one IDLE cycle, which is the accept cycle.
- Worst-case core stall is 2^LEN_W cycles per burst.

## Timing
- Reset (async, while `rst`=1): state IDLE, `cnt`=0, latched command 0, `m1_rdata_o`=0, `m1_rvalid_o`=0.
  - Combinational outputs are forced to: `mem_req_o`=0, `mem_we_o`=0, `hold_o`=0, `m1_ack_o`=0, `m1_beat_o`=0, `m1_done_o`=0.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is produced and remaining beats are discarded.
- Latency is counted from the ack cycle T:
  - beats occur in T+1..T+1+len;
  - done is asserted at T+1+len;
  - the last read data is valid at T+2+len;
  - IDLE resumes at T+2+len.
- `m1_rvalid_o` of the last read beat coincides with the first IDLE cycle, which may also be a new ack cycle.
- m0 is served in the same cycle as its request whenever not in BURST. `hold_o` is purely combinational from state and `m0_req_i`.
- Simultaneous `m0_req_i` and `m1_req_i` in IDLE: both are honoured, m0 access plus m1 ack.

## Structure
- Shared package holds:
  - state encodings `ARB_IDLE`=1'b0 and `ARB_BURST`=1'b1;
  - constant `ARB_WORD_STRIDE`=4.
- One sub-module is natural: `arb_burst_gen`. It contains the base/len latch, beat counter, address adder and last-beat compare. The top level keeps the FSM and the muxes.

## Test plan
- Core-only traffic: `m0_req_i`=1 write 0x1234_5678 to 0x10, then read 0x10 → `m0_rdata_o`=0x12345678, `hold_o` stays 0.
- Write burst at 0x100, len=3 → ack at T, beats at T+1..T+4 to 0x100/104/108/10C, done at T+4, IDLE at T+5.
- Read burst of the same region, len=3 → `m1_rvalid_o` at T+2..T+5 with the written data in order.
- Core request during a len=7 burst → `hold_o`=1 for exactly the 8 beat cycles with `mem_we_o` never from m0. Core access completes in the next IDLE cycle.
- Burst base 0xFFFF_FFF8, len=3 → addresses FFF8, FFFC, 0000, 0004; base 0x103 is treated as 0x100.
- Assert `rst` at beat 2 of a len=5 burst → all outputs go to reset values immediately, no done pulse. A new request after release is acked in the first cycle.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the two-master data memory arbiter:
// FSM state encoding and the byte stride between consecutive burst beats.
package data_mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int ARB_WORD_STRIDE = 4;

endpackage

// File: rtl/arb_burst_gen.sv
// Burst command latch and beat address generator for the burst master.
// Holds base/len/direction, counts beats and flags the last one.
module arb_burst_gen
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_base;
    logic              r_we;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_offset;

    // The base is word-aligned on load; the two low address bits are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
            r_we   <= 1'b0;
            r_len  <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_addr & ~ADDR_W'(3);
            r_we   <= i_we;
            r_len  <= i_len;
            r_cnt  <= '0;
        end else if (i_advance) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Address arithmetic is modulo 2^ADDR_W, so bursts wrap through zero.
    assign w_offset = ADDR_W'(r_cnt) * ADDR_W'(ARB_WORD_STRIDE);
    assign o_addr   = r_base + w_offset;
    assign o_we     = r_we;
    assign o_last   = (r_cnt == r_len);

endmodule

// File: rtl/data_mem_arb.sv
// Two-master arbiter for the data memory port: the core (m0) owns memory in IDLE,
// the burst master (m1) owns it in BURST while the core pipeline is held.
module data_mem_arb
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_raddr_i,
    input  logic [ADDR_W-1:0] m0_waddr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              hold_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LEN_W-1:0]  m1_len_i,
    output logic              m1_ack_o,
    output logic              m1_beat_o,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_rvalid_o,
    output logic              m1_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e        r_state;
    arb_state_e        w_nextState;
    logic [ADDR_W-1:0] w_beatAddr;
    logic              w_burstWe;
    logic              w_last;
    logic              w_inBurst;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    assign w_inBurst = (r_state == ARB_BURST);

    arb_burst_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_gen (
        .clk       (clk),
        .rst       (rst),
        .i_load    (m1_ack_o),
        .i_advance (w_inBurst),
        .i_addr    (m1_addr_i),
        .i_we      (m1_we_i),
        .i_len     (m1_len_i),
        .o_addr    (w_beatAddr),
        .o_we      (w_burstWe),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // The accept cycle is always an IDLE cycle, so back-to-back bursts leave the core a slot.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE:  if (m1_req_i) w_nextState = ARB_BURST;
            ARB_BURST: if (w_last)   w_nextState = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_raddr_o = m0_raddr_i;
        mem_waddr_o = m0_waddr_i;
        mem_wdata_o = m0_wdata_i;
        hold_o      = 1'b0;
        m1_ack_o    = 1'b0;
        m1_beat_o   = 1'b0;
        m1_done_o   = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB_IDLE: begin
                    mem_req_o = m0_req_i;
                    mem_we_o  = m0_req_i & m0_we_i;
                    m1_ack_o  = m1_req_i;
                end
                ARB_BURST: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = w_burstWe;
                    mem_raddr_o = w_beatAddr;
                    mem_waddr_o = w_beatAddr;
                    mem_wdata_o = m1_wdata_i;
                    hold_o      = m0_req_i;
                    m1_beat_o   = 1'b1;
                    m1_done_o   = w_last;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_inBurst & ~w_burstWe;
            if (w_inBurst && !w_burstWe) begin
                r_rdata <= mem_rdata_i;
            end
        end
    end

    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = r_rdata;
    assign m1_rvalid_o = r_rvalid;

endmodule
